axi_addr_window_guard: RTL
==========================

Name: axi_addr_window_guard

Overview:
- Sits directly upstream of the DDR address mapper, between the core's 64-bit AXI4 memory master and the mapper's slave port.
- The mapper keeps only addr[27:0], so any access outside the 256 MB window would silently alias.
- This block forwards in-window bursts unchanged and terminates out-of-window bursts locally with DECERR.
- It also bounds outstanding transactions per direction.

Parameters:
- ADDR_WIDTH, 32: AXI address width.
- WIN_BITS, 28: window size is 2^WIN_BITS bytes.
- WIN_TAG, 0: required value of addr[ADDR_WIDTH-1:WIN_BITS].
- MAX_OUTSTANDING, 8: maximum forwarded-but-unresponded bursts per direction. Legal range 1..255.

Ports:
- clock, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- s_axi_aw*, in/out, AXI4 AW bundle: id 4, addr ADDR_WIDTH, len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4, valid in, ready out. Slave side, from core.
- s_axi_w*, in/out, data 64, strb 8, last 1, valid in, ready out.
- s_axi_b*, out/in, id 4, resp 2, valid out, ready in.
- s_axi_ar*, in/out, same fields as AW.
- s_axi_r*, out/in, id 4, data 64, resp 2, last 1, valid out, ready in.
- m_axi_{aw,w,b,ar,r}*, mirror of the slave bundles. Master side, toward the mapper.

Behaviour:
- Legal address: addr[ADDR_WIDTH-1:WIN_BITS] == WIN_TAG, checked on the AW/AR start address only.
- Forwarded channels are combinational pass-through gated by FSM state. The block adds zero latency.
- Reset values: all s_/m_ valid and ready outputs 0, both FSMs in IDLE, both counters 0.
- Write FSM states: W_IDLE, W_PASS, W_ERR_DATA, W_ERR_RESP.
  - W_IDLE, legal AW: m_awvalid = s_awvalid and s_awready = m_awready, but only when wcnt < MAX_OUTSTANDING; otherwise both are 0. On AW handshake: wcnt++ and go to W_PASS.
  - W_IDLE, illegal AW: s_awready = 1 for one cycle and m_awvalid stays 0. Capture awid and go to W_ERR_DATA.
  - W_PASS: W channel passes through. On W handshake with wlast, go to W_IDLE. In every other state m_wvalid = 0 and s_wready = 0, except W_ERR_DATA.
  - W_ERR_DATA: s_wready = 1 and beats are discarded. On the beat with wlast, go to W_ERR_RESP.
  - W_ERR_RESP: wait until wcnt == 0, so ordering is preserved. Then drive s_bvalid = 1, bresp = 2'b11, bid = captured id. On s_bready, go to W_IDLE.
  - B pass-through from the master is active in all states except when the local B is driven; m_bready = s_bready.
  - wcnt decrements on every m_b handshake.
- Read FSM states: R_IDLE, R_ERR_WAIT, R_ERR_DATA.
  - R_IDLE, legal AR: pass through when rcnt < MAX_OUTSTANDING. rcnt++ on AR handshake.
  - R_IDLE, illegal AR: accept locally. Capture arid and arlen into beat counter rbeat, then go to R_ERR_WAIT.
  - R_ERR_WAIT: go to R_ERR_DATA when rcnt == 0.
  - R_ERR_DATA: s_rvalid = 1, rdata = 0, rresp = 2'b11, rid = captured id, rlast = (rbeat == 0). rbeat decrements on each handshake. Go to R_IDLE after the last beat. m_rready = 0 in this state.
  - rcnt decrements on an m_r handshake with rlast.
  - Counters are 8 bits. Simultaneous increment and decrement leaves the count unchanged. Counters never wrap because of the MAX_OUTSTANDING gate.
- If valid is held while the gate closes, the request waits. valid and payload are never dropped or modified.
- Reset asserted mid-burst aborts all state. The downstream slave is reset together with this block.

Optional Feature:
- Macro: ADDR_GUARD_ERR_LOG_EN.
- When defined, extra ports are present:
  - err_clear in 1.
  - err_valid out 1.
  - err_is_write out 1.
  - err_addr out ADDR_WIDTH.
- On the first rejected AW or AR while err_valid = 0: latch the address and direction, and set err_valid the next cycle. It stays sticky until err_clear.
- If a rejection and err_clear coincide, the new error is latched.
- Reset value of all log outputs is 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Legal write: AW addr 0x0000_1000, len 3, id 2 → identical AW/W on m_, 4 beats forwarded; m_ B OKAY id 2 returned on s_ unchanged; wcnt back to 0.
- Illegal read: AR addr 0x1000_0040, len 1, id 5 → no m_arvalid; 2 s_ R beats, rdata 0, rresp 2'b11, rid 5, rlast on beat 2 only.
- Illegal write behind a pending legal write: legal AW id 1 with no B yet, then AW 0x2000_0000 id 3 len 0 → W beat absorbed; DECERR B for id 3 issued only after id 1's B completes.
- Outstanding limit with MAX_OUTSTANDING = 2: 3 legal ARs with no R returned → 3rd s_arready held 0; after one rlast handshake it is accepted the next cycle.
- Backpressure: s_rready = 0 for 5 cycles during an error read → s_rvalid, rid and rlast held stable, no beat lost.
- With ADDR_GUARD_ERR_LOG_EN: two illegal ARs at 0x3000_0000 then 0x4000_0000 → err_addr = 0x3000_0000 and err_is_write = 0; after err_clear, a third illegal AW at 0x5000_0000 latches with err_is_write = 1.

Source files
------------

// File: rtl/axi_addr_window_guard.sv
// axi_addr_window_guard
// Guards the DDR address mapper's slave port. Bursts whose start address lies
// inside the 2^WIN_BITS byte window tagged WIN_TAG are passed through with no
// added latency; all others are absorbed here and answered with DECERR.
// Forwarded-but-unanswered bursts are bounded per direction by MAX_OUTSTANDING.
// Optional error log: define ADDR_GUARD_ERR_LOG_EN to add the err_* ports.
module axi_addr_window_guard #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned WIN_BITS        = 28,
    parameter int unsigned WIN_TAG         = 0,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef ADDR_GUARD_ERR_LOG_EN
    input  logic                  err_clear,
    output logic                  err_valid,
    output logic                  err_is_write,
    output logic [ADDR_WIDTH-1:0] err_addr,
`endif
    // Slave side (from core)
    input  logic [3:0]            s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [63:0]           s_axi_wdata,
    input  logic [7:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [3:0]            s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [3:0]            s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [3:0]            s_axi_rid,
    output logic [63:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // Master side (toward the mapper)
    output logic [3:0]            m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [63:0]           m_axi_wdata,
    output logic [7:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [3:0]            m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [3:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [3:0]            m_axi_rid,
    input  logic [63:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned       TAG_W     = ADDR_WIDTH - WIN_BITS;
    localparam logic [TAG_W-1:0]  WIN_TAG_V = TAG_W'(WIN_TAG);
    localparam logic [7:0]        MAX_CNT   = 8'(MAX_OUTSTANDING);
    localparam logic [1:0]        RESP_DEC  = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PASS,
        W_ERR_DATA,
        W_ERR_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ERR_WAIT,
        R_ERR_DATA
    } r_state_t;

    w_state_t   w_state, w_next;
    r_state_t   r_state, r_next;

    logic [7:0] wcnt;
    logic [7:0] rcnt;
    logic [7:0] rbeat;
    logic [3:0] err_bid;
    logic [3:0] err_rid;

    logic aw_legal, ar_legal;
    logic wcnt_open, rcnt_open;
    logic b_local, r_local;
    logic aw_fire, b_fire, ar_fire, r_done;
    logic aw_rej, ar_rej;

    assign aw_legal  = (s_axi_awaddr[ADDR_WIDTH-1:WIN_BITS] == WIN_TAG_V);
    assign ar_legal  = (s_axi_araddr[ADDR_WIDTH-1:WIN_BITS] == WIN_TAG_V);
    assign wcnt_open = (wcnt < MAX_CNT);
    assign rcnt_open = (rcnt < MAX_CNT);

    // Locally generated responses wait until every earlier forwarded burst
    // in the same direction has been answered, keeping response order intact.
    assign b_local = (w_state == W_ERR_RESP) && (wcnt == 8'd0);
    assign r_local = (r_state == R_ERR_DATA);

    // Request and data payloads are wired straight through; only the
    // valid/ready pairs are gated.
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;

    // Response payloads select between the mapper and the local DECERR source.
    assign s_axi_bid   = b_local ? err_bid  : m_axi_bid;
    assign s_axi_bresp = b_local ? RESP_DEC : m_axi_bresp;
    assign s_axi_rid   = r_local ? err_rid  : m_axi_rid;
    assign s_axi_rdata = r_local ? 64'd0    : m_axi_rdata;
    assign s_axi_rresp = r_local ? RESP_DEC : m_axi_rresp;
    assign s_axi_rlast = r_local ? (rbeat == 8'd0) : m_axi_rlast;

    assign aw_fire = m_axi_awvalid & m_axi_awready;
    assign b_fire  = m_axi_bvalid  & m_axi_bready;
    assign ar_fire = m_axi_arvalid & m_axi_arready;
    assign r_done  = m_axi_rvalid  & m_axi_rready & m_axi_rlast;
    assign aw_rej  = (w_state == W_IDLE) & s_axi_awvalid & s_axi_awready & ~aw_legal;
    assign ar_rej  = (r_state == R_IDLE) & s_axi_arvalid & s_axi_arready & ~ar_legal;

    // Write FSM state register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state plus AW/W/B handshake gating; all zero in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next        = w_state;
        m_axi_awvalid = 1'b0;
        s_axi_awready = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        if (!reset) begin
            case (w_state)
                W_IDLE: begin
                    if (aw_legal) begin
                        if (wcnt_open) begin
                            m_axi_awvalid = s_axi_awvalid;
                            s_axi_awready = m_axi_awready;
                            if (s_axi_awvalid && m_axi_awready) begin
                                w_next = W_PASS;
                            end
                        end
                    end else begin
                        s_axi_awready = 1'b1;
                        if (s_axi_awvalid) begin
                            w_next = W_ERR_DATA;
                        end
                    end
                end
                W_PASS: begin
                    m_axi_wvalid = s_axi_wvalid;
                    s_axi_wready = m_axi_wready;
                    if (s_axi_wvalid && m_axi_wready && s_axi_wlast) begin
                        w_next = W_IDLE;
                    end
                end
                W_ERR_DATA: begin
                    s_axi_wready = 1'b1;
                    if (s_axi_wvalid && s_axi_wlast) begin
                        w_next = W_ERR_RESP;
                    end
                end
                W_ERR_RESP: begin
                    if (b_local && s_axi_bready) begin
                        w_next = W_IDLE;
                    end
                end
                default: w_next = W_IDLE;
            endcase
            if (b_local) begin
                s_axi_bvalid = 1'b1;
            end else begin
                s_axi_bvalid = m_axi_bvalid;
                m_axi_bready = s_axi_bready;
            end
        end
    end

    // Outstanding-write counter and captured id of the rejected write.
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt    <= 8'd0;
            err_bid <= 4'd0;
        end else begin
            case ({aw_fire, b_fire})
                2'b10:   wcnt <= wcnt + 8'd1;
                2'b01:   wcnt <= wcnt - 8'd1;
                default: wcnt <= wcnt;
            endcase
            if (aw_rej) begin
                err_bid <= s_axi_awid;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state plus AR/R handshake gating; all zero in reset.
    always_comb begin
        r_next        = r_state;
        m_axi_arvalid = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        m_axi_rready  = 1'b0;
        if (!reset) begin
            case (r_state)
                R_IDLE: begin
                    if (ar_legal) begin
                        if (rcnt_open) begin
                            m_axi_arvalid = s_axi_arvalid;
                            s_axi_arready = m_axi_arready;
                        end
                    end else begin
                        s_axi_arready = 1'b1;
                        if (s_axi_arvalid) begin
                            r_next = R_ERR_WAIT;
                        end
                    end
                end
                R_ERR_WAIT: begin
                    if (rcnt == 8'd0) begin
                        r_next = R_ERR_DATA;
                    end
                end
                R_ERR_DATA: begin
                    if (s_axi_rready && (rbeat == 8'd0)) begin
                        r_next = R_IDLE;
                    end
                end
                default: r_next = R_IDLE;
            endcase
            if (r_local) begin
                s_axi_rvalid = 1'b1;
            end else begin
                s_axi_rvalid = m_axi_rvalid;
                m_axi_rready = s_axi_rready;
            end
        end
    end

    // Outstanding-read counter, plus id and remaining-beat count of the
    // rejected read burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            rcnt    <= 8'd0;
            rbeat   <= 8'd0;
            err_rid <= 4'd0;
        end else begin
            case ({ar_fire, r_done})
                2'b10:   rcnt <= rcnt + 8'd1;
                2'b01:   rcnt <= rcnt - 8'd1;
                default: rcnt <= rcnt;
            endcase
            if (ar_rej) begin
                rbeat   <= s_axi_arlen;
                err_rid <= s_axi_arid;
            end else if (r_local && s_axi_rready && (rbeat != 8'd0)) begin
                rbeat <= rbeat - 8'd1;
            end
        end
    end

`ifdef ADDR_GUARD_ERR_LOG_EN
    // Sticky log of the first rejected request; a rejection arriving together
    // with err_clear replaces the old entry. Writes win a same-cycle tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_valid    <= 1'b0;
            err_is_write <= 1'b0;
            err_addr     <= '0;
        end else if ((aw_rej || ar_rej) && (!err_valid || err_clear)) begin
            err_valid    <= 1'b1;
            err_is_write <= aw_rej;
            err_addr     <= aw_rej ? s_axi_awaddr : s_axi_araddr;
        end else if (err_clear) begin
            err_valid <= 1'b0;
        end
    end
`endif

endmodule
